// File: rtl/can_mac_rx_frame_ctrl.sv
// CAN MAC receive frame controller: walks base-format frame fields, hands frames upward, flags errors.
// Defining CAN_RX_CRC_CHECK_EN compiles in CRC-15 checking of received frames.
module can_mac_rx_frame_ctrl #(
  parameter int IDLE_BITS      = 11,
  parameter int MAX_DATA_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        can_clk_en,
  input  logic        des_bit,
  input  logic        des_valid,
  output logic        des_ready,
  input  logic        stuff_error,
  output logic        destuffing_enable,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic [10:0] frame_id,
  output logic        frame_rtr,
  output logic [3:0]  frame_dlc,
  output logic [63:0] frame_data,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic        overrun
);

  localparam int IW = $clog2(IDLE_BITS + 1);

  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_FORM  = 3'd2;
`ifdef CAN_RX_CRC_CHECK_EN
  localparam logic [2:0] ERR_CRC   = 3'd3;
`endif
  localparam logic [2:0] ERR_IDE   = 3'd4;

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC,
    S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF, S_INTERMISSION, S_ERROR
  } state_t;

  state_t         state_q;
  logic [IW-1:0]  idle_cnt_q;
  logic [5:0]     cnt_q;
  logic           destuff_en_q;
  logic [10:0]    id_q;
  logic           rtr_q;
  logic [3:0]     dlc_q;
  logic [63:0]    data_q;
  logic           frame_valid_q;
  logic [10:0]    frame_id_q;
  logic           frame_rtr_q;
  logic [3:0]     frame_dlc_q;
  logic [63:0]    frame_data_q;
  logic           err_valid_q;
  logic [2:0]     err_code_q;
  logic           overrun_q;

  logic           tick;
  logic           publish;
  logic           err_det;
  logic [2:0]     err_kind;
  logic [3:0]     dlc_full;
  logic [3:0]     dlc_eff;
  logic [5:0]     data_last;

`ifdef CAN_RX_CRC_CHECK_EN
  logic [14:0]    crc_q;
  logic [14:0]    crc_d;
  logic [14:0]    crc_rx_q;

  always_comb begin
    crc_d = {crc_q[13:0], 1'b0} ^ ((des_bit ^ crc_q[14]) ? 15'h4599 : 15'h0000);
  end
`endif

  // An overrun drops the new frame rather than stalling, so the bit stream is never back-pressured.
  assign des_ready = 1'b1;
  assign tick      = can_clk_en & des_valid & des_ready;

  always_comb begin
    dlc_full  = {dlc_q[2:0], des_bit};
    dlc_eff   = (dlc_q > 4'(MAX_DATA_BYTES)) ? 4'(MAX_DATA_BYTES) : dlc_q;
    data_last = 6'({dlc_eff, 3'b111} - 7'd8);
    publish   = tick && (state_q == S_EOF) && (cnt_q == 6'd6);
  end

  always_comb begin
    err_det  = 1'b0;
    err_kind = 3'd0;
    if (can_clk_en && destuff_en_q && stuff_error) begin
      err_det  = 1'b1;
      err_kind = ERR_STUFF;
    end else if (tick) begin
      case (state_q)
        S_IDE: if (des_bit) begin
          err_det  = 1'b1;
          err_kind = ERR_IDE;
        end
        S_CRC_DELIM: if (!des_bit) begin
          err_det  = 1'b1;
          err_kind = ERR_FORM;
        end
`ifdef CAN_RX_CRC_CHECK_EN
        else if (crc_q != crc_rx_q) begin
          err_det  = 1'b1;
          err_kind = ERR_CRC;
        end
`endif
        S_ACK_DELIM: if (!des_bit) begin
          err_det  = 1'b1;
          err_kind = ERR_FORM;
        end
        // A dominant last EOF bit is an overload indication and is tolerated.
        S_EOF: if (!des_bit && (cnt_q != 6'd6)) begin
          err_det  = 1'b1;
          err_kind = ERR_FORM;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_WAIT_IDLE;
      idle_cnt_q    <= '0;
      cnt_q         <= '0;
      destuff_en_q  <= 1'b0;
      id_q          <= '0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      data_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_id_q    <= '0;
      frame_rtr_q   <= 1'b0;
      frame_dlc_q   <= '0;
      frame_data_q  <= '0;
      err_valid_q   <= 1'b0;
      err_code_q    <= '0;
      overrun_q     <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_q         <= '0;
      crc_rx_q      <= '0;
`endif
    end else begin
      err_valid_q <= 1'b0;

      if (frame_valid_q && frame_ack) begin
        frame_valid_q <= 1'b0;
        overrun_q     <= 1'b0;
      end
      if (publish) begin
        if (!frame_valid_q || frame_ack) begin
          frame_valid_q <= 1'b1;
          frame_id_q    <= id_q;
          frame_rtr_q   <= rtr_q;
          frame_dlc_q   <= dlc_q;
          frame_data_q  <= data_q;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      if (err_det) begin
        state_q      <= S_ERROR;
        err_valid_q  <= 1'b1;
        err_code_q   <= err_kind;
        destuff_en_q <= 1'b0;
      end else if (state_q == S_ERROR) begin
        state_q    <= S_WAIT_IDLE;
        idle_cnt_q <= IW'(tick && des_bit);
      end else if (tick) begin
`ifdef CAN_RX_CRC_CHECK_EN
        if (state_q inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA}) crc_q <= crc_d;
`endif
        case (state_q)
          S_WAIT_IDLE: begin
            if (des_bit) begin
              if (idle_cnt_q == IW'(IDLE_BITS - 1)) begin
                state_q    <= S_IDLE;
                idle_cnt_q <= '0;
              end else begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
              end
            end else begin
              idle_cnt_q <= '0;
            end
          end
          S_IDLE: if (!des_bit) begin
            state_q      <= S_ID;
            destuff_en_q <= 1'b1;
            cnt_q        <= '0;
            id_q         <= '0;
            dlc_q        <= '0;
            data_q       <= '0;
            err_code_q   <= '0;
`ifdef CAN_RX_CRC_CHECK_EN
            crc_q        <= '0;
`endif
          end
          S_ID: begin
            id_q <= {id_q[9:0], des_bit};
            if (cnt_q == 6'd10) begin
              state_q <= S_RTR;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          S_RTR: begin
            rtr_q   <= des_bit;
            state_q <= S_IDE;
          end
          S_IDE: state_q <= S_R0;
          S_R0: begin
            state_q <= S_DLC;
            cnt_q   <= '0;
          end
          S_DLC: begin
            dlc_q <= dlc_full;
            if (cnt_q == 6'd3) begin
              cnt_q   <= '0;
              state_q <= (rtr_q || (dlc_full == 4'd0)) ? S_CRC : S_DATA;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          S_DATA: begin
            data_q[6'd63 - cnt_q] <= des_bit;
            if (cnt_q == data_last) begin
              state_q <= S_CRC;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          S_CRC: begin
`ifdef CAN_RX_CRC_CHECK_EN
            crc_rx_q <= {crc_rx_q[13:0], des_bit};
`endif
            // Stuffing ends with the last CRC bit; the delimiters onward are fixed-form.
            if (cnt_q == 6'd14) begin
              destuff_en_q <= 1'b0;
              state_q      <= S_CRC_DELIM;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          S_CRC_DELIM: state_q <= S_ACK_SLOT;
          S_ACK_SLOT:  state_q <= S_ACK_DELIM;
          S_ACK_DELIM: begin
            state_q <= S_EOF;
            cnt_q   <= '0;
          end
          S_EOF: begin
            if (cnt_q == 6'd6) begin
              state_q <= S_INTERMISSION;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          S_INTERMISSION: begin
            if (!des_bit) begin
              cnt_q <= '0;
            end else if (cnt_q == 6'd2) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          default: state_q <= S_WAIT_IDLE;
        endcase
      end
    end
  end

  assign destuffing_enable = destuff_en_q;
  assign frame_valid       = frame_valid_q;
  assign frame_id          = frame_id_q;
  assign frame_rtr         = frame_rtr_q;
  assign frame_dlc         = frame_dlc_q;
  assign frame_data        = frame_data_q;
  assign err_valid         = err_valid_q;
  assign err_code          = err_code_q;
  assign overrun           = overrun_q;

endmodule
